s12379_pixel_capture: RTL

Receive-side counterpart of the S12379 CCD timing driver: it watches the same SH/F1 timing the driver emits, samples the external video ADC once per pixel at a programmable delay after each F1 rising edge, strips leading dummy pixels and emits a framed active-pixel stream. It sits between the ADC input pins and the line-buffer/pixel-processing path, in the `sys_clk` domain shared with the driver.

---
 rtl/s12379_pkg.sv | 32 +++
 rtl/s12379_pixel_capture_if.sv | 38 +++
 rtl/s12379_edge_det.sv | 30 +++
 rtl/s12379_pixel_capture.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/s12379_pkg.sv
// ---------------------------------------------------------------------------
// s12379_pkg
// Shared definitions for the S12379 CCD timing driver and the receive-side
// pixel capture block: line geometry, datapath widths and the capture FSM
// state encoding.
// ---------------------------------------------------------------------------
package s12379_pkg;

  // Line geometry; must match the driver.
  localparam int LINE_WIDTH = 526;  // total pixel clocks per line
  localparam int DUMMY_LEAD = 14;   // leading dummy pixels discarded
  localparam int ACTIVE_PIX = 512;  // active pixels emitted per line

  // Datapath widths.
  localparam int ADC_W  = 12;
  localparam int IDX_W  = 10;
  localparam int DLY_W  = 8;
  localparam int LCNT_W = 16;

  typedef logic [IDX_W-1:0] pix_idx_t;

  // First and last pixel index that is forwarded downstream.
  localparam pix_idx_t IDX_FIRST = pix_idx_t'(DUMMY_LEAD);
  localparam pix_idx_t IDX_LAST  = pix_idx_t'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SH_HI,
    LINE
  } state_t;

endpackage

// File: rtl/s12379_pixel_capture_if.sv
// ---------------------------------------------------------------------------
// s12379_pixel_capture_if
// Bundles the timing inputs, ADC bus, error control and the framed pixel
// stream of the pixel capture block.
//   master : the driver/ADC side (drives sh, f1, sample_dly, adc_data,
//            err_clr; observes the pixel stream and status)
//   slave  : the capture block itself
// ---------------------------------------------------------------------------
interface s12379_pixel_capture_if;
  import s12379_pkg::*;

  // Timing and ADC side
  logic              sh;          // transfer-gate pulse
  logic              f1;          // shift pulse F1
  logic [DLY_W-1:0]  sample_dly;  // F1 rise -> sample delay, cycles
  logic [ADC_W-1:0]  adc_data;    // external ADC sample
  logic              err_clr;     // clears sticky error flags

  // Pixel stream and status
  logic [ADC_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_sol;
  logic              pix_eol;
  logic [LCNT_W-1:0] line_cnt;
  logic              err_short;
  logic              err_ovr;

  modport master (
    output sh, f1, sample_dly, adc_data, err_clr,
    input  pix_data, pix_valid, pix_sol, pix_eol, line_cnt, err_short, err_ovr
  );

  modport slave (
    input  sh, f1, sample_dly, adc_data, err_clr,
    output pix_data, pix_valid, pix_sol, pix_eol, line_cnt, err_short, err_ovr
  );

endinterface

// File: rtl/s12379_edge_det.sv
// ---------------------------------------------------------------------------
// s12379_edge_det
// One-register rise/fall detector for a clk-synchronous control input.
//   clk  : system clock
//   rst  : asynchronous active-high reset (clears the history register)
//   sig  : input being watched
//   rise : sig==1 this cycle and 0 last cycle
//   fall : sig==0 this cycle and 1 last cycle
// ---------------------------------------------------------------------------
module s12379_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/s12379_pixel_capture.sv
// ---------------------------------------------------------------------------
// s12379_pixel_capture
// Watches the SH/F1 timing emitted by the S12379 driver, samples the ADC a
// programmable number of cycles after each pixel F1 rise, drops the leading
// dummy pixels and emits a framed active-pixel stream.
//   sys_clk : system clock (shared with the driver)
//   rst     : asynchronous active-high reset
//   bus     : slave side of s12379_pixel_capture_if
//             in : sh, f1, sample_dly, adc_data, err_clr
//             out: pix_data, pix_valid, pix_sol, pix_eol, line_cnt,
//                  err_short, err_ovr (all registered, reset to 0)
// ---------------------------------------------------------------------------
module s12379_pixel_capture
  import s12379_pkg::*;
(
  input  logic                   sys_clk,
  input  logic                   rst,
  s12379_pixel_capture_if.slave  bus
);

  logic sh_rise, sh_fall, f1_rise, f1_fall_unused, sh_rise_unused_fall;

  s12379_edge_det u_sh_edge (
    .clk  (sys_clk),
    .rst  (rst),
    .sig  (bus.sh),
    .rise (sh_rise),
    .fall (sh_fall)
  );

  s12379_edge_det u_f1_edge (
    .clk  (sys_clk),
    .rst  (rst),
    .sig  (bus.f1),
    .rise (f1_rise),
    .fall (f1_fall_unused)
  );

  assign sh_rise_unused_fall = 1'b0;

  state_t            state;
  logic              skip;       // next F1 rise is the driver's load edge
  logic              pending;    // a sample is waiting for dly_cnt to expire
  logic [DLY_W-1:0]  dly_lat;    // sample_dly latched at SH fall
  logic [DLY_W-1:0]  dly_cnt;
  pix_idx_t          pix_idx;
  logic [ADC_W-1:0]  pix_data_q;
  logic              pix_valid_q, pix_sol_q, pix_eol_q;
  logic [LCNT_W-1:0] line_cnt_q;
  logic              err_short_q, err_ovr_q;
  logic              capture;

  // The counter is loaded with delay-1 on the F1 rise, so the sample lands on
  // the edge closing cycle E+delay. A zero delay samples on the detection
  // cycle itself. A new F1 rise always takes precedence over an expiring
  // older sample (that case is an overrun).
  assign capture = (state == LINE) && !sh_rise &&
                   ((f1_rise && !skip && dly_lat == '0) ||
                    (!f1_rise && pending && dly_cnt == '0));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      skip        <= 1'b0;
      pending     <= 1'b0;
      dly_lat     <= '0;
      dly_cnt     <= '0;
      pix_idx     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_sol_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      line_cnt_q  <= '0;
      err_short_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      pix_sol_q   <= 1'b0;
      pix_eol_q   <= 1'b0;

      // Clear first; any set below in the same cycle overrides it.
      if (bus.err_clr) begin
        err_short_q <= 1'b0;
        err_ovr_q   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sh_rise) state <= SH_HI;
        end

        SH_HI: begin
          if (sh_fall) begin
            dly_lat <= bus.sample_dly;
            pix_idx <= '0;
            skip    <= 1'b1;
            pending <= 1'b0;
            state   <= LINE;
          end
        end

        LINE: begin
          if (sh_rise) begin
            // Line cut short: abandon it without counting it.
            err_short_q <= 1'b1;
            pending     <= 1'b0;
            state       <= SH_HI;
          end else begin
            if (f1_rise) begin
              if (skip) begin
                skip <= 1'b0;
              end else begin
                if (pending) err_ovr_q <= 1'b1;
                pending <= (dly_lat != '0);
                dly_cnt <= dly_lat - 8'd1;
              end
            end else if (pending && dly_cnt != '0) begin
              dly_cnt <= dly_cnt - 8'd1;
            end

            if (capture) begin
              pending <= 1'b0;
              pix_idx <= pix_idx + pix_idx_t'(1);
              if (pix_idx >= IDX_FIRST) begin
                pix_data_q  <= bus.adc_data;
                pix_valid_q <= 1'b1;
                pix_sol_q   <= (pix_idx == IDX_FIRST);
                pix_eol_q   <= (pix_idx == IDX_LAST);
              end
              if (pix_idx == IDX_LAST) begin
                line_cnt_q <= line_cnt_q + 16'd1;
                state      <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_data  = pix_data_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_sol   = pix_sol_q;
  assign bus.pix_eol   = pix_eol_q;
  assign bus.line_cnt  = line_cnt_q;
  assign bus.err_short = err_short_q;
  assign bus.err_ovr   = err_ovr_q;

endmodule
